// File: rtl/sum_game_pkg.sv
// sum_game_pkg: shared constants for the sum-challenge game core.
//   - FSM state encodings (IDLE, LOAD, PLAY, CHECK, OVER)
//   - round result codes carried on result_code
//   - LFSR feedback tap mask and the nibble-to-digit fold helper
package sum_game_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [1:0] RES_CORRECT = 2'b00;
   localparam logic [1:0] RES_WRONG   = 2'b01;
   localparam logic [1:0] RES_TIMEOUT = 2'b10;

   // x^16+x^14+x^13+x^11+1, left-shifting Fibonacci form: feedback from bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic       valid;
      logic [1:0] code;
   } result_t;

   // Nibbles 10..15 fold onto 4..9 so every nibble yields a decimal digit
   function automatic logic [3:0] fold_digit(input logic [3:0] n);
      return (n > 4'd9) ? (n - 4'd6) : n;
   endfunction

endpackage

// File: rtl/lfsr_digit_gen.sv
// lfsr_digit_gen: free-running 16-bit LFSR plus per-operand digit extraction.
//   clk, rst      : clock, synchronous active-high reset (LFSR <= SEED)
//   digits[i]     : low nibble of the LFSR rotated right by 4*i, folded to 0..9
module lfsr_digit_gen
   import sum_game_pkg::*;
#(
   parameter int          NUM_OPERANDS = 3,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic [NUM_OPERANDS-1:0][3:0]  digits
);

   logic [15:0] lfsr_q;

   // Advances every cycle regardless of game state, so round content depends on player timing
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // A 16-bit register only has four nibbles, so operands 4..7 repeat 0..3
   genvar i;
   generate
      for (i = 0; i < NUM_OPERANDS; i++) begin : g_dig
         localparam int SH = (4 * i) % 16;
         assign digits[i] = fold_digit(lfsr_q[SH +: 4]);
      end
   endgenerate

endmodule

// File: rtl/sum_round_engine.sv
// sum_round_engine: sum-challenge game core.
//   clk, rst       : clock, synchronous active-high reset
//   start, abort   : 1-cycle game control pulses (abort has priority)
//   tick_1s        : 1-cycle per-second pulse, decrements the countdown in PLAY
//   answer_valid   : 1-cycle pulse qualifying answer_bcd (digit 0 in [3:0])
//   operands       : current round digits, operand 0 in [3:0]
//   secs_left      : countdown (binary)
//   score, lives   : current game state, held for display after abort/game over
//   best_score     : session best, cleared only by rst
//   playing        : high while waiting for an answer
//   result_valid/result_code : 1-cycle verdict, cycle after CHECK (2 cycles after answer)
//   game_over      : 1-cycle pulse on the first OVER cycle
module sum_round_engine
   import sum_game_pkg::*;
#(
   parameter int          NUM_OPERANDS  = 3,
   parameter int          ANSWER_DIGITS = 2,
   parameter int          ROUND_SECS    = 30,
   parameter int          NUM_LIVES     = 3,
   parameter int          SCORE_W       = 7,
   parameter int          MAX_SCORE     = 99,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         tick_1s,
   input  logic                         answer_valid,
   input  logic [4*ANSWER_DIGITS-1:0]   answer_bcd,
   output logic [4*NUM_OPERANDS-1:0]    operands,
   output logic [6:0]                   secs_left,
   output logic [SCORE_W-1:0]           score,
   output logic [2:0]                   lives,
   output logic [SCORE_W-1:0]           best_score,
   output logic                         playing,
   output logic                         result_valid,
   output logic [1:0]                   result_code,
   output logic                         game_over
);

   localparam int SUM_W   = $clog2(9 * NUM_OPERANDS + 1);
   localparam int ANS_MAX = 10 ** ANSWER_DIGITS;
   localparam int ANS_W   = $clog2(ANS_MAX);
   localparam int CMP_W   = (ANS_W > SUM_W) ? ANS_W : SUM_W;

   logic [2:0]                          state;
   logic [NUM_OPERANDS-1:0][3:0]        ops_q;
   logic [NUM_OPERANDS-1:0][3:0]        digits;
   logic [ANSWER_DIGITS-1:0][3:0]       ans_q;
   logic                                timeout_q;
   logic [6:0]                          secs_q;
   logic [SCORE_W-1:0]                  score_q;
   logic [SCORE_W-1:0]                  best_q;
   logic [2:0]                          lives_q;
   result_t                             res_q;
   logic                                game_over_q;

   logic [SUM_W-1:0]                    op_sum;
   logic [CMP_W-1:0]                    ans_bin;
   logic                                ans_bad;
   logic                                correct;

   lfsr_digit_gen #(
      .NUM_OPERANDS (NUM_OPERANDS),
      .SEED         (LFSR_SEED)
   ) u_gen (
      .clk    (clk),
      .rst    (rst),
      .digits (digits)
   );

   always_comb begin
      op_sum = '0;
      for (int i = 0; i < NUM_OPERANDS; i++)
         op_sum = op_sum + SUM_W'(ops_q[i]);
   end

   // Horner evaluation from the most significant digit; any non-decimal digit
   // makes the answer wrong even if its weighted value happens to match
   always_comb begin
      ans_bin = '0;
      ans_bad = 1'b0;
      for (int k = ANSWER_DIGITS - 1; k >= 0; k--) begin
         ans_bin = ans_bin * CMP_W'(10) + CMP_W'(ans_q[k]);
         if (ans_q[k] > 4'd9) ans_bad = 1'b1;
      end
   end

   assign correct = !timeout_q && !ans_bad && (ans_bin == CMP_W'(op_sum));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ops_q       <= '0;
         ans_q       <= '0;
         timeout_q   <= 1'b0;
         secs_q      <= '0;
         score_q     <= '0;
         best_q      <= '0;
         lives_q     <= '0;
         res_q       <= '0;
         game_over_q <= 1'b0;
      end else begin
         res_q.valid <= 1'b0;
         game_over_q <= 1'b0;
         if (abort) begin
            state  <= ST_IDLE;
            secs_q <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_OVER: begin
                  if (start) begin
                     score_q <= '0;
                     lives_q <= 3'(NUM_LIVES);
                     state   <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  ops_q  <= digits;
                  secs_q <= 7'(ROUND_SECS);
                  state  <= ST_PLAY;
               end
               ST_PLAY: begin
                  // an answer arriving with the final tick is still judged as an answer
                  if (answer_valid) begin
                     ans_q     <= answer_bcd;
                     timeout_q <= 1'b0;
                     state     <= ST_CHECK;
                  end else if (tick_1s) begin
                     if (secs_q <= 7'd1) begin
                        secs_q    <= '0;
                        timeout_q <= 1'b1;
                        state     <= ST_CHECK;
                     end else begin
                        secs_q <= secs_q - 7'd1;
                     end
                  end
               end
               ST_CHECK: begin
                  res_q.valid <= 1'b1;
                  if (correct) begin
                     res_q.code <= RES_CORRECT;
                     if (score_q < SCORE_W'(MAX_SCORE)) score_q <= score_q + 1'b1;
                     state <= ST_LOAD;
                  end else begin
                     res_q.code <= timeout_q ? RES_TIMEOUT : RES_WRONG;
                     lives_q    <= lives_q - 3'd1;
                     if (lives_q <= 3'd1) begin
                        state       <= ST_OVER;
                        game_over_q <= 1'b1;
                        if (score_q > best_q) best_q <= score_q;
                     end else begin
                        // a wrong guess keeps the same round and the running timer
                        state <= timeout_q ? ST_LOAD : ST_PLAY;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign operands     = ops_q;
   assign secs_left    = secs_q;
   assign score        = score_q;
   assign lives        = lives_q;
   assign best_score   = best_q;
   assign playing      = (state == ST_PLAY);
   assign result_valid = res_q.valid;
   assign result_code  = res_q.code;
   assign game_over    = game_over_q;

endmodule

// File: tb/tb_sum_round_engine.sv
// Directed bench for sum_round_engine: default build plus a MAX_SCORE=3 build
// driven with identical stimulus. Operands are predicted from a bench LFSR model.
module tb_sum_round_engine;

   logic        clk = 1'b0;
   logic        rst, start, abort, tick_1s, answer_valid;
   logic [7:0]  answer_bcd;

   logic [11:0] operands, operands2;
   logic [6:0]  secs_left, secs_left2;
   logic [6:0]  score, score2, best_score, best_score2;
   logic [2:0]  lives, lives2;
   logic        playing, playing2, result_valid, result_valid2, game_over, game_over2;
   logic [1:0]  result_code, result_code2;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] m_lfsr, m_prev;
   logic [11:0] cur_ops;
   int          cur_sum;

   always #5 clk = ~clk;

   sum_round_engine dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .tick_1s(tick_1s),
      .answer_valid(answer_valid), .answer_bcd(answer_bcd),
      .operands(operands), .secs_left(secs_left), .score(score), .lives(lives),
      .best_score(best_score), .playing(playing), .result_valid(result_valid),
      .result_code(result_code), .game_over(game_over));

   sum_round_engine #(.MAX_SCORE(3)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .tick_1s(tick_1s),
      .answer_valid(answer_valid), .answer_bcd(answer_bcd),
      .operands(operands2), .secs_left(secs_left2), .score(score2), .lives(lives2),
      .best_score(best_score2), .playing(playing2), .result_valid(result_valid2),
      .result_code(result_code2), .game_over(game_over2));

   // Reference LFSR; m_prev holds the value the DUT saw in the previous cycle (the LOAD cycle)
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_prev <= m_lfsr;
   end

   function automatic logic [11:0] exp_ops(input logic [15:0] l);
      logic [11:0] r;
      logic [3:0]  n;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         n = l[(4*i) % 16 +: 4];
         r[4*i +: 4] = (n > 4'd9) ? n - 4'd6 : n;
      end
      return r;
   endfunction

   function automatic int ops_sum(input logic [11:0] o);
      return int'(o[3:0]) + int'(o[7:4]) + int'(o[11:8]);
   endfunction

   function automatic logic [7:0] to_bcd(input int s);
      logic [3:0] hi, lo;
      hi = 4'(s / 10);
      lo = 4'(s % 10);
      return {hi, lo};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1s = 1'b1; step(); tick_1s = 1'b0;
      end
   endtask

   // drive an answer and land on the cycle where the verdict is visible
   task automatic do_answer(input logic [7:0] v);
      answer_bcd = v; answer_valid = 1'b1; step(); answer_valid = 1'b0;
      step();
   endtask

   // step out of LOAD into PLAY and predict the new round
   task automatic enter_play(input string tag);
      step();
      cur_ops = exp_ops(m_prev);
      cur_sum = ops_sum(cur_ops);
      chk(tag, operands, cur_ops);
   endtask

   logic [7:0] bad_ans;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; tick_1s = 1'b0;
      answer_valid = 1'b0; answer_bcd = '0;
      step(); step();
      chk("rst_ops", operands, 0);
      chk("rst_secs", secs_left, 0);
      chk("rst_score", score, 0);
      chk("rst_lives", lives, 0);
      chk("rst_best", best_score, 0);
      chk("rst_playing", playing, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_go", game_over, 0);

      // 1: correct answer
      rst = 1'b0; start = 1'b1; step(); start = 1'b0;
      enter_play("t1_ops");
      chk("t1_playing", playing, 1);
      chk("t1_secs", secs_left, 30);
      chk("t1_lives", lives, 3);
      answer_bcd = to_bcd(cur_sum); answer_valid = 1'b1; step(); answer_valid = 1'b0;
      chk("t1_rv_early", result_valid, 0);
      step();
      chk("t1_rv", result_valid, 1);
      chk("t1_code", result_code, 2'b00);
      chk("t1_score", score, 1);
      enter_play("t1_new_ops");

      // 2: wrong answer keeps round and timer
      ticks(2);
      chk("t2_secs_pre", secs_left, 28);
      do_answer(to_bcd(cur_sum + 1));
      chk("t2_rv", result_valid, 1);
      chk("t2_code", result_code, 2'b01);
      chk("t2_lives", lives, 2);
      chk("t2_secs", secs_left, 28);
      chk("t2_ops", operands, cur_ops);
      chk("t2_playing", playing, 1);

      // 4: answer coincides with final tick
      ticks(27);
      chk("t4_secs", secs_left, 1);
      tick_1s = 1'b1;
      do_answer(to_bcd(cur_sum));
      tick_1s = 1'b0;
      chk("t4_code", result_code, 2'b00);
      chk("t4_lives", lives, 2);
      chk("t4_score", score, 2);
      enter_play("t4_ops");

      // two more correct rounds: saturating build stops at 3
      do_answer(to_bcd(cur_sum));
      enter_play("s3_ops");
      do_answer(to_bcd(cur_sum));
      chk("s4_score", score, 4);
      chk("sat_rv", result_valid2, 1);
      chk("sat_score", score2, 3);
      enter_play("s4_ops");

      // 3: timeout
      ticks(29);
      chk("t3_secs1", secs_left, 1);
      ticks(1);
      chk("t3_secs0", secs_left, 0);
      chk("t3_rv_early", result_valid, 0);
      step();
      chk("t3_rv", result_valid, 1);
      chk("t3_code", result_code, 2'b10);
      chk("t3_lives", lives, 1);
      enter_play("t3_ops");
      chk("t3_reload", secs_left, 30);

      // 5: third miss ends the game
      do_answer(to_bcd(cur_sum + 1));
      chk("t5_code", result_code, 2'b01);
      chk("t5_go", game_over, 1);
      chk("t5_lives", lives, 0);
      chk("t5_best", best_score, 4);
      chk("t5_best_sat", best_score2, 3);
      chk("t5_playing", playing, 0);
      step();
      chk("t5_go_pulse", game_over, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("t5_restart_score", score, 0);
      chk("t5_restart_lives", lives, 3);
      chk("t5_best_hold", best_score, 4);
      enter_play("t5_ops");

      // 6: non-decimal digit is always wrong
      if (cur_sum >= 10 && (cur_sum % 10) <= 5)
         bad_ans = {4'(cur_sum / 10 - 1), 4'(10 + cur_sum % 10)};
      else
         bad_ans = 8'h0A;
      do_answer(bad_ans);
      chk("t6_code", result_code, 2'b01);
      chk("t6_lives", lives, 2);

      // abort beats a simultaneous answer
      abort = 1'b1; answer_bcd = to_bcd(cur_sum); answer_valid = 1'b1; step();
      abort = 1'b0; answer_valid = 1'b0;
      chk("ab_playing", playing, 0);
      chk("ab_secs", secs_left, 0);
      chk("ab_rv", result_valid, 0);
      chk("ab_lives", lives, 2);
      step();
      chk("ab_rv_late", result_valid, 0);
      tick_1s = 1'b1; answer_valid = 1'b1; step(); tick_1s = 1'b0; answer_valid = 1'b0;
      step();
      chk("idle_secs", secs_left, 0);
      chk("idle_rv", result_valid, 0);
      chk("idle_best", best_score, 4);

      // reset mid-game clears everything including the best score
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("mid_playing", playing, 1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_best", best_score, 0);
      chk("mid_lives", lives, 0);
      chk("mid_ops", operands, 0);
      chk("mid_playing_off", playing, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
